// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared constants and helpers for the binary-to-one-hot decoder family.
//   DEC_N_DEFAULT / DEC_M_DEFAULT : default index width and output count
//                                   (4-to-16 chip-select decode).
//   DEC_N_MAX                     : widest supported index.
//   max_index(n)                  : largest index representable in n bits.
//   onehot_of(index, width)       : one-hot vector with bit 'index' set,
//                                   all zero when index >= width.
// -----------------------------------------------------------------------------
package decoder_pkg;

    localparam int DEC_N_DEFAULT  = 4;
    localparam int DEC_M_DEFAULT  = 16;
    localparam int DEC_N_MAX      = 16;
    localparam int DEC_ONEHOT_MAX = 1 << DEC_N_MAX;

    // Usable in localparam expressions: 2^n - 1.
    function automatic int unsigned max_index(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

    // Generic one-hot helper; callers take the low 'width' bits.
    function automatic logic [DEC_ONEHOT_MAX-1:0] onehot_of(
        input logic [DEC_N_MAX-1:0] index,
        input int unsigned          width
    );
        logic [DEC_ONEHOT_MAX-1:0] v;
        v = '0;
        if ({16'd0, index} < width) begin
            v[index] = 1'b1;
        end
        return v;
    endfunction

endpackage : decoder_pkg

// File: rtl/decoder_n_m_core.sv
// -----------------------------------------------------------------------------
// decoder_n_m_core
// Purely combinational decode of an N-bit index into M one-hot lines plus an
// out-of-range indication.
//   a      [N-1:0] : binary index
//   onehot [M-1:0] : bit a set when a < M, all zero otherwise
//   oor            : 1 when a >= M (only reachable when M < 2^N)
// -----------------------------------------------------------------------------
module decoder_n_m_core
    import decoder_pkg::*;
#(
    parameter int N = DEC_N_DEFAULT,
    parameter int M = DEC_M_DEFAULT
) (
    input  logic [N-1:0] a,
    output logic [M-1:0] onehot,
    output logic         oor
);

    localparam int unsigned A_MAX = max_index(N);

    // Reject illegal configurations at elaboration time.
    generate
        if (N < 1 || N > DEC_N_MAX) begin : g_bad_n
            $error("decoder_n_m_core: N=%0d outside 1..%0d", N, DEC_N_MAX);
        end
        if (M < 1 || M > int'(A_MAX) + 1) begin : g_bad_m
            $error("decoder_n_m_core: M=%0d outside 1..2^N", M);
        end
    endgenerate

    // One comparator per output line; lines >= M simply do not exist, so an
    // out-of-range index leaves every line low.
    generate
        for (genvar gi = 0; gi < M; gi++) begin : g_line
            assign onehot[gi] = (a == N'(gi));
        end
    endgenerate

    // One extra bit so M = 2^N is representable; in that case oor folds to 0.
    localparam logic [N:0] M_VAL = (N + 1)'(M);
    assign oor = ({1'b0, a} >= M_VAL);

endmodule : decoder_n_m_core

// File: rtl/decoder_n_m.sv
// -----------------------------------------------------------------------------
// decoder_n_m
// Registered, enable-gated binary-to-one-hot decoder (one clock of latency).
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low reset
//   en             : load enable; outputs update only when en = 1
//   A      [N-1:0] : binary index
//   Y      [M-1:0] : registered one-hot decode of A
//   oor            : registered out-of-range flag (captured A >= M)
// Build option: define DECODER_ACTIVE_LOW_EN to make Y active-low (selected
// line 0, others 1; reset and out-of-range value all 1s). oor stays
// active-high either way.
// -----------------------------------------------------------------------------
module decoder_n_m
    import decoder_pkg::*;
#(
    parameter int N = DEC_N_DEFAULT,
    parameter int M = DEC_M_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] A,
    output logic [M-1:0] Y,
    output logic         oor
);

    logic [M-1:0] onehot;
    logic         oor_next;
    logic [M-1:0] y_next;
    logic [M-1:0] y_reg;
    logic         oor_reg;

    decoder_n_m_core #(
        .N (N),
        .M (M)
    ) u_core (
        .a      (A),
        .onehot (onehot),
        .oor    (oor_next)
    );

`ifdef DECODER_ACTIVE_LOW_EN
    // Inverting the all-zero out-of-range decode yields the all-ones idle
    // value, so no separate out-of-range path is needed.
    localparam logic [M-1:0] Y_IDLE = '1;
    assign y_next = ~onehot;
`else
    localparam logic [M-1:0] Y_IDLE = '0;
    assign y_next = onehot;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_reg   <= Y_IDLE;
            oor_reg <= 1'b0;
        end else if (en) begin
            y_reg   <= y_next;
            oor_reg <= oor_next;
        end
    end

    assign Y   = y_reg;
    assign oor = oor_reg;

endmodule : decoder_n_m

// File: tb/tb_decoder_n_m.sv
// -----------------------------------------------------------------------------
// tb_decoder_n_m
// Table-driven bench for decoder_n_m. Three instances share clk/rst_n:
//   u_d16 : N=4, M=16 (sweep, hold, enable, async reset)
//   u_d10 : N=4, M=10 (out-of-range)
//   u_d2  : N=1, M=2  (small config, random one-hot check)
// Expected values are written as active-high; with DECODER_ACTIVE_LOW_EN
// defined they are inverted within each instance's width.
// -----------------------------------------------------------------------------
module tb_decoder_n_m;

`ifdef DECODER_ACTIVE_LOW_EN
    localparam bit ACT_LOW = 1'b1;
`else
    localparam bit ACT_LOW = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        en0, en1, en2;
    logic [3:0]  a0, a1;
    logic [0:0]  a2;
    logic [15:0] y0;
    logic [9:0]  y1;
    logic [1:0]  y2;
    logic        oor0, oor1, oor2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    decoder_n_m #(.N(4), .M(16)) u_d16 (
        .clk (clk), .rst_n (rst_n), .en (en0), .A (a0), .Y (y0), .oor (oor0)
    );
    decoder_n_m #(.N(4), .M(10)) u_d10 (
        .clk (clk), .rst_n (rst_n), .en (en1), .A (a1), .Y (y1), .oor (oor1)
    );
    decoder_n_m #(.N(1), .M(2)) u_d2 (
        .clk (clk), .rst_n (rst_n), .en (en2), .A (a2), .Y (y2), .oor (oor2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  a;
        logic        en;
        logic [15:0] y;    // active-high expectation
        logic        oor;
    } vec_t;

    // Y comparison with polarity adjustment inside the given width mask.
    task automatic check_y(input string name, input logic [15:0] act,
                           input logic [15:0] exp, input logic [15:0] mask);
        logic [15:0] exp_p;
        exp_p = ACT_LOW ? (~exp & mask) : exp;
        total_cnt++;
        if (act === exp_p) pass_cnt++;
        else $display("FAIL %s: Y got %h expected %h", name, act, exp_p);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    vec_t tab0[22];
    vec_t tab1[5];

    initial begin
        logic [1:0] exp2;
        logic [1:0] raw2;

        // ---- vector tables -------------------------------------------------
        for (int i = 0; i < 16; i++) begin
            tab0[i] = '{a: 4'(i), en: 1'b1, y: 16'h0001 << i, oor: 1'b0};
        end
        tab0[16] = '{a: 4'd15, en: 1'b1, y: 16'h8000, oor: 1'b0}; // repeat MSB
        tab0[17] = '{a: 4'd5,  en: 1'b1, y: 16'h0020, oor: 1'b0};
        tab0[18] = '{a: 4'd9,  en: 1'b0, y: 16'h0020, oor: 1'b0}; // hold
        tab0[19] = '{a: 4'd9,  en: 1'b0, y: 16'h0020, oor: 1'b0};
        tab0[20] = '{a: 4'd9,  en: 1'b0, y: 16'h0020, oor: 1'b0};
        tab0[21] = '{a: 4'd9,  en: 1'b1, y: 16'h0200, oor: 1'b0};

        tab1[0] = '{a: 4'd9,  en: 1'b1, y: 16'h0200, oor: 1'b0};
        tab1[1] = '{a: 4'd10, en: 1'b1, y: 16'h0000, oor: 1'b1};
        tab1[2] = '{a: 4'd15, en: 1'b1, y: 16'h0000, oor: 1'b1};
        tab1[3] = '{a: 4'd0,  en: 1'b1, y: 16'h0001, oor: 1'b0};
        tab1[4] = '{a: 4'd12, en: 1'b1, y: 16'h0000, oor: 1'b1};

        // ---- reset state ---------------------------------------------------
        rst_n = 1'b0;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        a0 = 4'd0; a1 = 4'd0; a2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_y("reset_y16", y0, 16'h0000, 16'hFFFF);
        check_bit("reset_oor16", oor0, 1'b0);
        check_y("reset_y10", {6'd0, y1}, 16'h0000, 16'h03FF);
        check_bit("reset_oor10", oor1, 1'b0);
        check_y("reset_y2", {14'd0, y2}, 16'h0000, 16'h0003);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- M=16: sweep, repeat, enable hold ------------------------------
        for (int i = 0; i < 22; i++) begin
            a0  = tab0[i].a;
            en0 = tab0[i].en;
            @(posedge clk);
            #1;
            $display("d16 vec %0d: A=%0d en=%b Y=%h oor=%b", i, tab0[i].a, tab0[i].en, y0, oor0);
            check_y($sformatf("d16_y_%0d", i), y0, tab0[i].y, 16'hFFFF);
            check_bit($sformatf("d16_oor_%0d", i), oor0, tab0[i].oor);
        end
        en0 = 1'b0;

        // ---- M=10: out-of-range --------------------------------------------
        for (int i = 0; i < 5; i++) begin
            a1  = tab1[i].a;
            en1 = tab1[i].en;
            @(posedge clk);
            #1;
            $display("d10 vec %0d: A=%0d Y=%h oor=%b", i, tab1[i].a, y1, oor1);
            check_y($sformatf("d10_y_%0d", i), {6'd0, y1}, tab1[i].y, 16'h03FF);
            check_bit($sformatf("d10_oor_%0d", i), oor1, tab1[i].oor);
        end
        en1 = 1'b0;

        // ---- async reset mid-cycle -----------------------------------------
        a0 = 4'd5; en0 = 1'b1;
        @(posedge clk);
        #1;
        check_y("pre_rst_y16", y0, 16'h0020, 16'hFFFF);
        en0 = 1'b0;
        #2;
        rst_n = 1'b0;   // well before the next rising edge
        #1;
        $display("async reset: Y16=%h oor16=%b Y10=%h oor10=%b", y0, oor0, y1, oor1);
        check_y("async_rst_y16", y0, 16'h0000, 16'hFFFF);
        check_bit("async_rst_oor16", oor0, 1'b0);
        check_y("async_rst_y10", {6'd0, y1}, 16'h0000, 16'h03FF);
        check_bit("async_rst_oor10", oor1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after release acts normally.
        a1 = 4'd9; en1 = 1'b1;
        @(posedge clk);
        #1;
        check_y("post_rst_y10", {6'd0, y1}, 16'h0200, 16'h03FF);
        en1 = 1'b0;

        // ---- N=1, M=2 ------------------------------------------------------
        a2 = 1'b0; en2 = 1'b1;
        @(posedge clk);
        #1;
        $display("d2: A=0 Y=%b", y2);
        check_y("d2_a0", {14'd0, y2}, 16'h0001, 16'h0003);
        a2 = 1'b1;
        @(posedge clk);
        #1;
        $display("d2: A=1 Y=%b", y2);
        check_y("d2_a1", {14'd0, y2}, 16'h0002, 16'h0003);

        exp2 = 2'b10;
        for (int i = 0; i < 100; i++) begin
            en2 = 1'($urandom_range(0, 1));
            a2  = 1'($urandom_range(0, 1));
            if (en2) exp2 = a2 ? 2'b10 : 2'b01;
            @(posedge clk);
            #1;
            raw2 = ACT_LOW ? ~y2 : y2;
            check_y($sformatf("d2_rand_%0d", i), {14'd0, y2}, {14'd0, exp2}, 16'h0003);
            check_bit($sformatf("d2_onehot_%0d", i), ($countones(raw2) <= 1), 1'b1);
            check_bit($sformatf("d2_oor_%0d", i), oor2, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_decoder_n_m
